// File: rtl/wram_b_port.sv
// B-bus responder for the WRAM access port: pointer registers, write FIFO, read prefetch and a WRAM req/ack master.
// Optional build macro WRAM_B_PORT_ADDR_READBACK_EN makes the three pointer registers readable.
module wram_b_port #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'h80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_en,
    input  logic [7:0]  b_addr,
    input  logic        b_write,
    input  logic        b_read,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_oe,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);
    localparam int unsigned IW = $clog2(FIFO_DEPTH);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [16:0]   ptr_q, ptr_d;
    logic [IW:0]   count_q, count_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic          pf_valid_q, pf_valid_d, stale_q, stale_d;
    logic [7:0]    pf_data_q, pf_data_d, rdata_q, rdata_d;
    logic          rdata_oe_q, rdata_oe_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [16:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [16:0]   fifo_addr_q [FIFO_DEPTH];
    logic [7:0]    fifo_data_q [FIFO_DEPTH];

    logic wr_s, rd_s, hit_dat_s, hit_lo_s, hit_mid_s, hit_hi_s;
    logic full_s, stall_s, push_s, pop_s, rd_ok_s, ptr_wr_s, touch_s, pf_fill_s;

    assign wr_s      = cpu_en & b_write;
    assign rd_s      = cpu_en & b_read;
    assign hit_dat_s = (b_addr == BASE_ADDR);
    assign hit_lo_s  = (b_addr == BASE_ADDR + 8'd1);
    assign hit_mid_s = (b_addr == BASE_ADDR + 8'd2);
    assign hit_hi_s  = (b_addr == BASE_ADDR + 8'd3);
    assign full_s    = (count_q == FULL_CNT);
    assign stall_s   = full_s | ~pf_valid_q;
    // Writes only need FIFO room; reads need valid prefetched data.
    assign push_s    = wr_s & hit_dat_s & ~full_s;
    assign rd_ok_s   = rd_s & hit_dat_s & ~stall_s;
    assign ptr_wr_s  = wr_s & (hit_lo_s | hit_mid_s | hit_hi_s);
    assign touch_s   = push_s | rd_ok_s | ptr_wr_s;
    assign pop_s     = (state_q == ST_WR) & mem_ack;
    assign pf_fill_s = (state_q == ST_RD) & mem_ack & ~stale_q;

    // Pointer update: register loads win over the auto-increment.
    always_comb begin
        ptr_d = ptr_q;
        if (wr_s && hit_lo_s) begin
            ptr_d[7:0] = wdata;
        end else if (wr_s && hit_mid_s) begin
            ptr_d[15:8] = wdata;
        end else if (wr_s && hit_hi_s) begin
            ptr_d[16] = wdata[0];
        end else if (push_s || rd_ok_s) begin
            ptr_d = ptr_q + 17'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Read data return; a stalled $80 read re-presents the last value.
    always_comb begin
        rdata_d    = rdata_q;
        rdata_oe_d = 1'b0;
        if (rd_s && hit_dat_s) begin
            rdata_oe_d = 1'b1;
            if (rd_ok_s) begin
                rdata_d = pf_data_q;
            end else begin
                rdata_d = rdata_q;
            end
`ifdef WRAM_B_PORT_ADDR_READBACK_EN
        end else if (rd_s && hit_lo_s) begin
            rdata_oe_d = 1'b1;
            rdata_d    = ptr_q[7:0];
        end else if (rd_s && hit_mid_s) begin
            rdata_oe_d = 1'b1;
            rdata_d    = ptr_q[15:8];
        end else if (rd_s && hit_hi_s) begin
            rdata_oe_d = 1'b1;
            rdata_d    = {7'd0, ptr_q[16]};
`endif
        end else begin
            rdata_oe_d = 1'b0;
            rdata_d    = rdata_q;
        end
    end

    // FIFO occupancy and index bookkeeping.
    always_comb begin
        wr_idx_d = push_s ? wr_idx_q + IW'(1) : wr_idx_q;
        rd_idx_d = pop_s  ? rd_idx_q + IW'(1) : rd_idx_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (IW+1)'(1);
            2'b01:   count_d = count_q - (IW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Memory master: drain writes first, then refill the prefetch.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        stale_d     = stale_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d     = ST_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = fifo_addr_q[rd_idx_q];
                    mem_wdata_d = fifo_data_q[rd_idx_q];
                end else if (!pf_valid_q) begin
                    state_d    = ST_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = ptr_q;
                    stale_d    = touch_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    stale_d = stale_q | touch_s;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        pf_data_d  = pf_fill_s ? mem_rdata : pf_data_q;
        pf_valid_d = (pf_valid_q | pf_fill_s) & ~touch_s;
    end

    // Write-buffer storage; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_q[wr_idx_q] <= ptr_q;
            fifo_data_q[wr_idx_q] <= wdata;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 17'd0;
            count_q     <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pf_valid_q  <= 1'b0;
            pf_data_q   <= 8'd0;
            stale_q     <= 1'b0;
            rdata_q     <= 8'd0;
            rdata_oe_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 17'd0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            pf_valid_q  <= pf_valid_d;
            pf_data_q   <= pf_data_d;
            stale_q     <= stale_d;
            rdata_q     <= rdata_d;
            rdata_oe_q  <= rdata_oe_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign rdata_oe  = rdata_oe_q;
    assign stall     = stall_s;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_wram_b_port.sv
// Randomized + directed bench for wram_b_port against a transaction-level model of pointer and WRAM contents.
module tb_wram_b_port;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_en = 1'b0, b_write = 1'b0, b_read = 1'b0;
    logic [7:0]  b_addr = 8'h00, wdata = 8'h00;
    logic [7:0]  rdata;
    logic        rdata_oe, stall, mem_req, mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    wram_b_port #(.FIFO_DEPTH(4), .BASE_ADDR(8'h80)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .b_addr(b_addr),
        .b_write(b_write), .b_read(b_read), .wdata(wdata), .rdata(rdata),
        .rdata_oe(rdata_oe), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: WRAM image as seen by the bus, pointer, last returned byte.
    logic [7:0]  smem [0:131071];
    logic [7:0]  rmem [0:131071];
    logic [24:0] exp_wq [$];
    logic [16:0] m_ptr = 17'd0;
    logic [7:0]  m_rdata = 8'd0;
    logic [16:0] last_fetch = 17'd0;
    bit          blk = 1'b0;
    bit          in_req = 1'b0;
    int          wait_cnt = 0;

    // WRAM responder with random ack latency; checks every write against the expected order.
    always @(negedge clk) begin
        logic [25:0] e26;
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        if (!reset_n || !mem_req) begin
            in_req = 1'b0;
        end else if (!blk) begin
            if (!in_req) begin
                in_req   = 1'b1;
                wait_cnt = $urandom_range(0, 2);
            end
            if (wait_cnt == 0) begin
                mem_ack = 1'b1;
                in_req  = 1'b0;
                if (mem_we) begin
                    e26 = (exp_wq.size() > 0) ? {1'b1, exp_wq.pop_front()} : 26'd0;
                    check("mem_write", {6'd0, 1'b1, mem_addr, mem_wdata}, {6'd0, e26});
                    smem[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata  = smem[mem_addr];
                    last_fetch = mem_addr;
                end
            end else begin
                wait_cnt--;
            end
        end
    end

    task automatic bus(input bit wr, input logic [7:0] a, input logic [7:0] d);
        cpu_en = 1'b1; b_write = wr; b_read = ~wr; b_addr = a; wdata = d;
        @(posedge clk); #1;
        cpu_en = 1'b0; b_write = 1'b0; b_read = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (stall && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("stall_release", {31'd0, stall}, 32'd0);
    endtask

    task automatic set_ptr(input logic [16:0] p);
        @(negedge clk); bus(1'b1, 8'h81, p[7:0]);
        @(negedge clk); bus(1'b1, 8'h82, p[15:8]);
        @(negedge clk); bus(1'b1, 8'h83, {7'd0, p[16]});
        m_ptr = p;
    endtask

    task automatic push_model(input logic [7:0] d);
        exp_wq.push_back({m_ptr, d});
        rmem[m_ptr] = d;
        m_ptr = m_ptr + 17'd1;
    endtask

    task automatic data_wr(input logic [7:0] d);
        wait_ready();
        bus(1'b1, 8'h80, d);
        push_model(d);
    endtask

    task automatic data_rd(input string tag);
        wait_ready();
        check({tag, "_fetch_addr"}, {15'd0, last_fetch}, {15'd0, m_ptr});
        bus(1'b0, 8'h80, 8'h00);
        check({tag, "_oe"}, {31'd0, rdata_oe}, 32'd1);
        check({tag, "_data"}, {24'd0, rdata}, {24'd0, rmem[m_ptr]});
        m_rdata = rmem[m_ptr];
        m_ptr = m_ptr + 17'd1;
    endtask

    task automatic reg_rd(input logic [1:0] idx);
        logic [7:0] exp;
        @(negedge clk);
        bus(1'b0, 8'h80 + {6'd0, idx}, 8'h00);
`ifdef WRAM_B_PORT_ADDR_READBACK_EN
        case (idx)
            2'd1:    exp = m_ptr[7:0];
            2'd2:    exp = m_ptr[15:8];
            default: exp = {7'd0, m_ptr[16]};
        endcase
        check("rb_oe", {31'd0, rdata_oe}, 32'd1);
        check("rb_data", {24'd0, rdata}, {24'd0, exp});
        m_rdata = exp;
`else
        exp = m_rdata;
        check("rb_oe", {31'd0, rdata_oe}, 32'd0);
        check("rb_hold", {24'd0, rdata}, {24'd0, exp});
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int r;
        int n;
        for (int a = 0; a < 131072; a++) begin
            smem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
            rmem[a] = smem[a];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_oe", {31'd0, rdata_oe}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {15'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); reset_n = 1'b1;

        // 1: ordered writes, then fetch past them
        set_ptr(17'h11000);
        data_wr(8'hAA);
        data_wr(8'hBB);
        data_rd("t1");
        // 2: pointer wrap
        set_ptr(17'h1FFFF);
        data_wr(8'h55);
        check("t2_wrap", {15'd0, m_ptr}, 32'd0);
        data_rd("t2");
        // 3: read observes earlier write
        set_ptr(17'h00100);
        data_wr(8'h77);
        set_ptr(17'h00100);
        data_rd("t3");
        check("t3_val", {24'd0, rdata}, 32'h77);
        wait_ready();
        check("t3_next_fetch", {15'd0, last_fetch}, 32'h101);

        // 4: fill FIFO with ack held, drop fifth write, stalled read
        wait_ready();
        blk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            d = 8'hC0 + 8'(i);
            bus(1'b1, 8'h80, d);
            push_model(d);
        end
        check("t4_full_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); bus(1'b1, 8'h80, 8'hEE);
        @(negedge clk); bus(1'b0, 8'h80, 8'h00);
        check("t4_err_oe", {31'd0, rdata_oe}, 32'd1);
        check("t4_err_data", {24'd0, rdata}, {24'd0, m_rdata});
        blk = 1'b0;
        data_rd("t4");
        check("t4_drained", exp_wq.size(), 32'd0);

        // 5: pointer write during pending fetch discards result
        set_ptr(17'h00200);
        wait_ready();
        blk = 1'b1;
        @(negedge clk); bus(1'b1, 8'h82, 8'h02);
        n = 0;
        @(negedge clk);
        while (!(mem_req && !mem_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_req", {31'd0, mem_req & ~mem_we}, 32'd1);
        check("t5_addr", {15'd0, mem_addr}, 32'h200);
        smem[17'h200] = 8'h3C;
        rmem[17'h200] = 8'h3C;
        @(negedge clk); bus(1'b1, 8'h81, 8'h10);
        m_ptr = 17'h00210;
        blk = 1'b0;
        data_rd("t5");

        // 6: async reset mid-transfer with queued writes
        set_ptr(17'h03000);
        wait_ready();
        blk = 1'b1;
        bus(1'b1, 8'h80, 8'h11); push_model(8'h11);
        @(negedge clk); bus(1'b1, 8'h80, 8'h22); push_model(8'h22);
        repeat (2) @(posedge clk);
        #2;
        check("t6_req_pre", {31'd0, mem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_req", {31'd0, mem_req}, 32'd0);
        check("t6_stall", {31'd0, stall}, 32'd1);
        check("t6_rdata", {24'd0, rdata}, 32'd0);
        while (exp_wq.size() > 0) begin
            logic [24:0] e;
            e = exp_wq.pop_front();
            rmem[e[24:8]] = smem[e[24:8]];
        end
        m_ptr = 17'd0;
        m_rdata = 8'd0;
        @(negedge clk); reset_n = 1'b1; blk = 1'b0;
        data_rd("t6");

        // Random mix
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    set_ptr(($urandom_range(0, 3) == 0) ? 17'h1FFFE : 17'($urandom));
                2, 3, 4: data_wr(8'($urandom));
                5, 6, 7: data_rd("rnd");
                8: begin
                    @(negedge clk); bus(1'b0, 8'h90, 8'h00);
                    check("unmapped_oe", {31'd0, rdata_oe}, 32'd0);
                    check("unmapped_hold", {24'd0, rdata}, {24'd0, m_rdata});
                end
                default: reg_rd(2'($urandom_range(1, 3)));
            endcase
        end
        data_rd("final");
        check("final_drained", exp_wq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
